// File: rtl/shadow_reg_stack.sv
// Shadow register stack: buffers captured exception frames and streams them
// to memory, and restores a frame from memory into a readable buffer.
module shadow_reg_stack #(
  parameter int XLEN    = 64,
  parameter int NrRegs  = 16,
  parameter int NrBanks = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   save_i,
  output logic                   save_ready_o,
  input  logic [NrRegs*XLEN-1:0] save_data_i,
  input  logic [XLEN-1:0]        save_esf_i,
  output logic                   st_valid_o,
  input  logic                   st_ready_i,
  output logic [XLEN-1:0]        st_addr_o,
  output logic [XLEN-1:0]        st_data_o,
  output logic [4:0]             save_level_o,
  input  logic                   load_valid_i,
  output logic                   load_ack_o,
  input  logic [XLEN-1:0]        load_esf_i,
  output logic                   ld_valid_o,
  input  logic                   ld_ready_i,
  output logic [XLEN-1:0]        ld_addr_o,
  input  logic                   ld_rvalid_i,
  input  logic [XLEN-1:0]        ld_rdata_i,
  output logic [4:0]             load_level_o,
  input  logic [4:0]             raddr_i,
  output logic [XLEN-1:0]        rdata_o,
  input  logic [11:0]            page_offset_i,
  output logic                   page_offset_match_o,
  input  logic                   mret_valid_i,
  output logic                   mret_ready_o,
  input  logic                   flush_i
);

  localparam int PW = (NrBanks > 1) ? $clog2(NrBanks) : 1;
  localparam int CW = $clog2(NrBanks + 1);
  localparam int IW = $clog2(NrRegs);
  localparam logic [XLEN-1:0] STRIDE = XLEN'(XLEN / 8);
  localparam logic [4:0] LAST = 5'(NrRegs - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_REQ,
    LOAD_WAIT
  } state_e;

  logic [NrRegs*XLEN-1:0] fifo_data [NrBanks];
  logic [XLEN-1:0]        fifo_esf  [NrBanks];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic [4:0]             k_q;
  logic                   empty, full;
  logic                   push, pop, st_hs;
  logic [NrRegs*XLEN-1:0] head_data;
  logic [XLEN-1:0]        head_esf;

  state_e          state_q, state_d;
  logic [4:0]      j_q;
  logic [5:0]      level_q;
  logic [XLEN-1:0] ld_esf_q;
  logic            ack_q;
  logic            accept, resp, abort;
  logic [XLEN-1:0] rbuf [NrRegs];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    if (p == PW'(NrBanks - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(NrBanks));
  assign head_data = fifo_data[rd_ptr];
  assign head_esf  = fifo_esf[rd_ptr];

  assign st_hs = st_valid_o && st_ready_i;
  assign pop   = st_hs && (k_q == LAST);
  // A full FIFO still takes a capture when the head retires this cycle
  assign push  = save_i && (!full || pop);

  assign save_ready_o = !full;
  assign st_valid_o   = !empty;
  assign save_level_o = empty ? 5'd0 : k_q;
  assign st_addr_o    = empty ? '0 : head_esf + XLEN'(k_q) * STRIDE;
  assign st_data_o    = empty ? '0 : head_data[int'(k_q)*XLEN +: XLEN];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= save_data_i;
      fifo_esf[wr_ptr]  <= save_esf_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      k_q    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (st_hs) k_q <= pop ? 5'd0 : k_q + 5'd1;
    end
  end

  always_comb begin
    logic [PW:0] sum;
    logic [PW-1:0] idx;
    logic [11:0] a;
    page_offset_match_o = 1'b0;
    sum = '0;
    idx = '0;
    a   = '0;
    for (int b = 0; b < NrBanks; b++) begin
      sum = {1'b0, rd_ptr} + (PW+1)'(b);
      if (sum >= (PW+1)'(NrBanks)) sum = sum - (PW+1)'(NrBanks);
      idx = sum[PW-1:0];
      if (b < int'(count)) begin
        for (int r = 0; r < NrRegs; r++) begin
          a = fifo_esf[idx][11:0] + 12'(r * (XLEN / 8));
          // Head registers already stored can no longer alias
          if ((b != 0 || r >= int'(k_q)) && a == page_offset_i)
            page_offset_match_o = 1'b1;
        end
      end
    end
  end

  assign abort = flush_i && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    resp       = 1'b0;
    ld_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid_i && empty && !save_i) begin
          accept  = 1'b1;
          state_d = LOAD_REQ;
        end
      end
      LOAD_REQ: begin
        ld_valid_o = 1'b1;
        if (flush_i) state_d = IDLE;
        else if (ld_ready_i) state_d = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if (flush_i) state_d = IDLE;
        else if (ld_rvalid_i) begin
          resp    = 1'b1;
          state_d = (j_q == LAST) ? IDLE : LOAD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      j_q      <= '0;
      level_q  <= '0;
      ld_esf_q <= '0;
      ack_q    <= 1'b0;
      for (int i = 0; i < NrRegs; i++) rbuf[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept;
      if (accept) begin
        ld_esf_q <= load_esf_i;
        j_q      <= '0;
        level_q  <= 6'(NrRegs);
      end else if (abort) begin
        j_q     <= '0;
        level_q <= '0;
      end else if (resp) begin
        rbuf[j_q[IW-1:0]] <= ld_rdata_i;
        level_q <= level_q - 6'd1;
        j_q     <= (j_q == LAST) ? 5'd0 : j_q + 5'd1;
      end
    end
  end

  assign load_ack_o   = ack_q;
  assign load_level_o = level_q[4:0];
  assign ld_addr_o    = (state_q == LOAD_REQ) ? ld_esf_q + XLEN'(j_q) * STRIDE : '0;
  assign mret_ready_o = (state_q == IDLE) && (level_q == '0);

  always_comb begin
    rdata_o = '0;
    if ({1'b0, raddr_i} < 6'(NrRegs)) rdata_o = rbuf[raddr_i[IW-1:0]];
  end

  logic unused;
  assign unused = mret_valid_i;

endmodule

// File: tb/tb_shadow_reg_stack.sv
// Directed bench for shadow_reg_stack with 4 registers, 64-bit, 2 banks.
module tb_shadow_reg_stack;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         save = 0;
  logic         save_ready;
  logic [255:0] save_data = '0;
  logic [63:0]  save_esf = '0;
  logic         st_valid;
  logic         st_ready = 0;
  logic [63:0]  st_addr, st_data;
  logic [4:0]   save_level;
  logic         load_valid = 0;
  logic         load_ack;
  logic [63:0]  load_esf = '0;
  logic         ld_valid;
  logic         ld_ready = 0;
  logic [63:0]  ld_addr;
  logic         ld_rvalid = 0;
  logic [63:0]  ld_rdata = '0;
  logic [4:0]   load_level;
  logic [4:0]   raddr = '0;
  logic [63:0]  rdata;
  logic [11:0]  page_offset = '0;
  logic         match;
  logic         mret_valid = 0;
  logic         mret_ready;
  logic         flush = 0;

  int n_chk = 0;
  int n_fail = 0;

  shadow_reg_stack #(.XLEN(64), .NrRegs(4), .NrBanks(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .save_i(save), .save_ready_o(save_ready),
    .save_data_i(save_data), .save_esf_i(save_esf),
    .st_valid_o(st_valid), .st_ready_i(st_ready),
    .st_addr_o(st_addr), .st_data_o(st_data),
    .save_level_o(save_level),
    .load_valid_i(load_valid), .load_ack_o(load_ack),
    .load_esf_i(load_esf),
    .ld_valid_o(ld_valid), .ld_ready_i(ld_ready),
    .ld_addr_o(ld_addr), .ld_rvalid_i(ld_rvalid),
    .ld_rdata_i(ld_rdata), .load_level_o(load_level),
    .raddr_i(raddr), .rdata_o(rdata),
    .page_offset_i(page_offset), .page_offset_match_o(match),
    .mret_valid_i(mret_valid), .mret_ready_o(mret_ready),
    .flush_i(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] frame(input logic [63:0] base);
    logic [255:0] v;
    for (int r = 0; r < 4; r++) v[r*64 +: 64] = base + 64'(r);
    return v;
  endfunction

  initial begin
    #3;
    chk("rst_save_ready", save_ready, 1);
    chk("rst_st_valid", st_valid, 0);
    chk("rst_mret_ready", mret_ready, 1);
    chk("rst_load_ack", load_ack, 0);
    chk("rst_load_level", load_level, 0);
    chk("rst_save_level", save_level, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1;
    tick();

    // single frame, continuous drain
    save = 1; save_esf = 64'h1000; save_data = frame(64'hA0);
    st_ready = 1;
    tick();
    save = 0;
    for (int r = 0; r < 4; r++) begin
      chk("s1_valid", st_valid, 1);
      chk("s1_addr", st_addr, 64'h1000 + 64'(8*r));
      chk("s1_data", st_data, 64'hA0 + 64'(r));
      chk("s1_level", save_level, 5'(r));
      tick();
    end
    chk("s1_done", st_valid, 0);

    // fill both banks with the store port stalled
    st_ready = 0;
    save = 1; save_esf = 64'h3000; save_data = frame(64'hB0);
    #1 chk("fill0_ready", save_ready, 1);
    tick();
    save_esf = 64'h4000; save_data = frame(64'hC0);
    chk("fill1_ready", save_ready, 1);
    tick();
    save_esf = 64'h5000; save_data = frame(64'hD0);
    chk("full_ready", save_ready, 0);
    chk("stall_addr0", st_addr, 64'h3000);
    tick();
    chk("stall_addr1", st_addr, 64'h3000);
    chk("stall_level", save_level, 0);
    save = 0;
    st_ready = 1;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 4; r++) begin
        if (f == 0 && r == 3) begin
          save = 1;
          #1 chk("full_pushpop_ready", save_ready, 0);
        end
        chk("d_addr", st_addr, 64'h3000 + 64'(f*64'h1000) + 64'(8*r));
        chk("d_data", st_data, 64'hB0 + 64'(f*16) + 64'(r));
        tick();
        save = 0;
      end
    end
    chk("d_done", st_valid, 0);

    // page offset alias check at head k=1
    st_ready = 0;
    save = 1; save_esf = 64'h2000; save_data = frame(64'hE0);
    tick();
    save = 0; st_ready = 1;
    tick();
    st_ready = 0;
    chk("po_level", save_level, 1);
    page_offset = 12'h008;
    #1 chk("po_008", match, 1);
    page_offset = 12'h000;
    #1 chk("po_000", match, 0);
    page_offset = 12'h018;
    #1 chk("po_018", match, 1);
    page_offset = 12'h020;
    #1 chk("po_020", match, 0);

    // load waits for the store stream to finish
    load_valid = 1; load_esf = 64'h8000;
    tick();
    chk("ld_pend_ack", load_ack, 0);
    st_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ld_wait_ack", load_ack, 0);
    end
    st_ready = 0;
    tick();
    load_valid = 0;
    chk("ld_ack", load_ack, 1);
    chk("ld_mret_busy", mret_ready, 0);
    for (int j = 0; j < 4; j++) begin
      chk("ld_valid", ld_valid, 1);
      chk("ld_addr", ld_addr, 64'h8000 + 64'(8*j));
      chk("ld_level", load_level, 5'(4 - j));
      ld_ready = 1;
      tick();
      ld_ready = 0;
      chk("ld_wait_valid", ld_valid, 0);
      ld_rvalid = 1; ld_rdata = 64'hD00 + 64'(j);
      tick();
      ld_rvalid = 0;
      chk("ld_level_after", load_level, 5'(3 - j));
    end
    chk("ld_ack_low", load_ack, 0);
    chk("ld_mret", mret_ready, 1);
    for (int i = 0; i < 5; i++) begin
      raddr = 5'(i);
      #1 chk("rbuf", rdata, (i < 4) ? 64'hD00 + 64'(i) : 64'h0);
    end

    // flush during LOAD_WAIT at j=2
    load_valid = 1; load_esf = 64'h9000;
    tick();
    load_valid = 0;
    for (int j = 0; j < 2; j++) begin
      ld_ready = 1;
      tick();
      ld_ready = 0; ld_rvalid = 1; ld_rdata = 64'hE0 + 64'(j);
      tick();
      ld_rvalid = 0;
    end
    ld_ready = 1;
    tick();
    ld_ready = 0;
    chk("fl_level_before", load_level, 2);
    flush = 1; ld_rvalid = 1; ld_rdata = 64'hEE;
    tick();
    flush = 0;
    chk("fl_level", load_level, 0);
    chk("fl_mret", mret_ready, 1);
    chk("fl_ld_valid", ld_valid, 0);
    tick();
    ld_rvalid = 0;
    chk("fl_late_valid", ld_valid, 0);
    raddr = 5'd0;
    #1 chk("fl_rbuf0", rdata, 64'hE0);
    raddr = 5'd1;
    #1 chk("fl_rbuf1", rdata, 64'hE1);
    raddr = 5'd2;
    #1 chk("fl_rbuf2", rdata, 64'hD02);

    // save beats load on an empty FIFO, then reset mid-drain
    save = 1; save_esf = 64'h6000; save_data = frame(64'hF0);
    load_valid = 1;
    tick();
    save = 0;
    chk("sv_win_valid", st_valid, 1);
    chk("sv_win_ld", ld_valid, 0);
    st_ready = 1;
    tick();
    chk("sv_win_ack", load_ack, 0);
    load_valid = 0;
    tick();
    chk("rd_level_mid", save_level, 2);
    rst_n = 0;
    #1;
    chk("rd_save_ready", save_ready, 1);
    chk("rd_st_valid", st_valid, 0);
    chk("rd_save_level", save_level, 0);
    raddr = 5'd0;
    #1 chk("rd_rbuf", rdata, 0);
    rst_n = 1;
    tick();
    chk("rd_after_valid", st_valid, 0);
    chk("rd_after_ld", ld_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shadow_reg_stack.md
SHADOW_REG_STACK -- requirements
Module: shadow_reg_stack

Interface
REQ-001 SHALL have parameter XLEN, default 64: register and data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter NrRegs, default 16: registers per exception frame; legal range 2..32.
REQ-003 SHALL have parameter NrBanks, default 2: captured frames buffered awaiting store; legal range 1..8.
REQ-004 SHALL have ports, one per line:
- clk_i  in  1  clock; the only clock
- rst_ni  in  1  asynchronous active-low reset
- save_i  in  1  capture request
- save_ready_o  out  1  capture can be accepted
- save_data_i  in  NrRegs*XLEN  register snapshot; reg i at bits [i*XLEN +: XLEN]
- save_esf_i  in  XLEN  exception stack frame base address for this capture
- st_valid_o  out  1  store request valid
- st_ready_i  in  1  store request accepted
- st_addr_o  out  XLEN  store address
- st_data_o  out  XLEN  store data
- save_level_o  out  5  index of the next register to be stored
- load_valid_i  in  1  restore request
- load_ack_o  out  1  restore request accepted
- load_esf_i  in  XLEN  restore frame base address
- ld_valid_o  out  1  load request valid
- ld_ready_i  in  1  load request accepted
- ld_addr_o  out  XLEN  load address
- ld_rvalid_i  in  1  load response valid
- ld_rdata_i  in  XLEN  load response data
- load_level_o  out  5  registers not yet restored
- raddr_i  in  5  restore-buffer read address
- rdata_o  out  XLEN  restore-buffer read data
- page_offset_i  in  12  page offset of a pending load elsewhere
- page_offset_match_o  out  1  page_offset_i hits a frame still being stored
- mret_valid_i  in  1  mret commit request
- mret_ready_o  out  1  mret may commit
- flush_i  in  1  abort an in-progress restore

Function
REQ-005 SHALL hold captured frames in a FIFO of NrBanks entries; each entry holds data plus ESF base.
REQ-006 SHALL assert save_ready_o when the FIFO is not full; when save_i && save_ready_o, SHALL push the frame at the clock edge.
REQ-007 SHALL accept a push and a pop in the same cycle when the FIFO is full.
- save_ready_o stays low in that cycle.
REQ-008 SHALL drive the store stream from the FIFO head.
- Register index k runs 0..NrRegs-1.
- st_addr_o = ESF + k*(XLEN/8), modulo 2^XLEN.
- st_data_o = reg k.
REQ-009 SHALL advance k only on st_valid_o && st_ready_i; st_addr_o/st_data_o SHALL be held stable while st_valid_o && !st_ready_i.
REQ-010 SHALL pop the head and reset k to 0 on the handshake of k = NrRegs-1.
- The next frame's first store may be valid the following cycle.
REQ-011 SHALL drive save_level_o = k while the FIFO is non-empty, else 0.
REQ-012 SHALL use state machine IDLE/LOAD_REQ/LOAD_WAIT.
- IDLE->LOAD_REQ when load_valid_i && FIFO empty && no store in flight; load_ack_o is pulsed one cycle on this transition.
- While the FIFO is non-empty, load_ack_o SHALL stay low and the request stays pending.
REQ-013 In LOAD_REQ SHALL issue ld_valid_o with ld_addr_o = load ESF + j*(XLEN/8), j from 0.
- Each ld_ready_i handshake moves to LOAD_WAIT.
REQ-014 In LOAD_WAIT, ld_rvalid_i SHALL write ld_rdata_i into restore buffer entry j and decrement load_level_o.
- If j < NrRegs-1: j+1 and back to LOAD_REQ.
- Otherwise: to IDLE.
REQ-015 load_level_o SHALL be NrRegs on acceptance, decrement by 1 per response, and be 0 in IDLE.
REQ-016 rdata_o SHALL be combinational on raddr_i: restore buffer entry raddr_i; 0 when raddr_i >= NrRegs.
REQ-017 mret_ready_o SHALL be high only in IDLE with load_level_o = 0.
REQ-018 page_offset_match_o SHALL be high when the FIFO is non-empty and page_offset_i equals bits [11:0] of any address k' in [k, NrRegs-1] of the head frame, or any address of a non-head frame.
REQ-019 flush_i in LOAD_REQ or LOAD_WAIT SHALL return to IDLE next cycle and set load_level_o = 0.
- A response arriving in the flush cycle SHALL be dropped.
- flush_i SHALL have no effect on the store FIFO.
REQ-020 save_i and load_valid_i in the same cycle with an empty FIFO: the save SHALL win, and the load is not acknowledged.

Reset
REQ-021 On rst_ni low, asynchronously:
- FIFO empty; k=0; j=0; state IDLE.
- All outputs 0, except save_ready_o=1 and mret_ready_o=1.
- Restore buffer cleared to 0.
REQ-022 Reset asserted mid-store or mid-load SHALL discard all progress; no partial request SHALL be issued after release.

Verification
REQ-023 NrRegs=4, XLEN=64: save ESF 0x1000, st_ready_i always 1 -> stores to 0x1000, 0x1008, 0x1010, 0x1018 on 4 consecutive cycles; save_level_o 0,1,2,3.
REQ-024 NrBanks=2: three back-to-back saves, st_ready_i=0 -> third save sees save_ready_o=0; releasing ready drains 8 stores in order.
REQ-025 Load pending during a store -> load_ack_o only after the last store handshake; then 4 loads, load_level_o 4,3,2,1,0; mret_ready_o rises after the final response.
REQ-026 Store head at k=1, ESF 0x2000, page_offset_i=0x008 -> match=1; page_offset_i=0x000 -> match=0.
REQ-027 flush_i during LOAD_WAIT with j=2 -> IDLE next cycle, load_level_o=0, late ld_rvalid_i ignored.
REQ-028 Reset mid-drain -> save_ready_o=1, st_valid_o=0, save_level_o=0 immediately.
